// File: rtl/sha256_compress.sv
`default_nettype none
// ============================================================================
// Module   : sha256_compress
// Brief    : SHA-256 compression of one 512-bit block. W[0..63] is read from
//            an external W generator, one round per returned word.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_compress (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] init_hash,
    input  logic         w_rdy,
    input  logic [31:0]  w_data,
    output logic         w_read,
    output logic [5:0]   w_addr,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_ROUND    = 3'd2,
        S_FINAL    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [255:0]  r_hin;
    logic [255:0]  r_hash_out;
    logic [31:0]   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [5:0]    r_rd_cnt;
    logic [5:0]    r_rnd;
    logic          r_w_read;
    logic [1:0]    r_vld;
    logic [31:0]   w_k;
    logic [31:0]   w_t1;
    logic [31:0]   w_t2;

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        k = 32'h0;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    always_comb begin
        w_k  = k_rom(r_rnd);
        w_t1 = r_h + big_sigma1(r_e) + ((r_e & r_f) ^ (~r_e & r_g)) + w_k + w_data;
        w_t2 = big_sigma0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_next = S_WAIT_RDY;
            S_WAIT_RDY: if (w_rdy) w_state_next = S_ROUND;
            S_ROUND:    if (r_vld[1] && (r_rnd == 6'd63)) w_state_next = S_FINAL;
            S_FINAL:    w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hin      <= 256'h0;
            r_hash_out <= 256'h0;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= 256'h0;
            r_rd_cnt   <= 6'd0;
            r_rnd      <= 6'd0;
            r_w_read   <= 1'b0;
            r_vld      <= 2'b00;
        end else begin
            r_state <= w_state_next;
            // r_vld[1] marks the cycle w_data carries the word read two cycles earlier
            r_vld   <= {r_vld[0], r_w_read};
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hin    <= init_hash;
                        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= init_hash;
                        r_rd_cnt <= 6'd0;
                        r_rnd    <= 6'd0;
                        r_w_read <= 1'b0;
                        r_vld    <= 2'b00;
                    end
                end
                S_WAIT_RDY: begin
                    if (w_rdy) begin
                        r_w_read <= 1'b1;
                        r_rd_cnt <= 6'd0;
                    end
                end
                S_ROUND: begin
                    if (r_w_read) begin
                        if (r_rd_cnt == 6'd63) r_w_read <= 1'b0;
                        else                   r_rd_cnt <= r_rd_cnt + 6'd1;
                    end
                    if (r_vld[1]) begin
                        r_h <= r_g;
                        r_g <= r_f;
                        r_f <= r_e;
                        r_e <= r_d + w_t1;
                        r_d <= r_c;
                        r_c <= r_b;
                        r_b <= r_a;
                        r_a <= w_t1 + w_t2;
                        if (r_rnd != 6'd63) r_rnd <= r_rnd + 6'd1;
                    end
                end
                S_FINAL: begin
                    r_hash_out <= {r_hin[255:224] + r_a, r_hin[223:192] + r_b,
                                   r_hin[191:160] + r_c, r_hin[159:128] + r_d,
                                   r_hin[127:96]  + r_e, r_hin[95:64]   + r_f,
                                   r_hin[63:32]   + r_g, r_hin[31:0]    + r_h};
                end
                default: ;
            endcase
        end
    end

    assign w_read   = r_w_read;
    assign w_addr   = r_rd_cnt;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign hash_out = r_hash_out;

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_compress
// Brief    : Scoreboard bench for sha256_compress with a 2-cycle W generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_compress;

    logic         clock;
    logic         reset;
    logic         start;
    logic [255:0] init_hash;
    logic         w_rdy;
    logic [31:0]  w_data;
    logic         w_read;
    logic [5:0]   w_addr;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;

    localparam logic [255:0] c_iv =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] c_exp_abc =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_exp_empty =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] c_exp_two =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] c_msg_abc   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] c_msg_empty = {32'h80000000, 480'h0};
    localparam logic [511:0] c_msg_b1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] c_msg_b2 = {480'h0, 32'h000001c0};

    typedef struct packed {
        logic         chk;
        logic [255:0] exp;
    } sb_t;

    sb_t          sb_q[$];
    int           total;
    int           bad;
    logic         prev_done;
    logic [31:0]  wmem [0:63];
    logic [5:0]   gen_addr;
    logic [255:0] mid_hash;

    sha256_compress dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .init_hash (init_hash),
        .w_rdy     (w_rdy),
        .w_data    (w_data),
        .w_read    (w_read),
        .w_addr    (w_addr),
        .busy      (busy),
        .done      (done),
        .hash_out  (hash_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // W generator model: address registered, then data registered
    always @(posedge clock) begin
        gen_addr <= w_addr;
        w_data   <= wmem[gen_addr];
    end

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    task automatic load_msg(input logic [511:0] m);
        logic [31:0] w [0:63];
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[511 - 32*t -: 32];
            else        w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
            wmem[t] = w[t];
        end
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_block(input logic [255:0] iv, input logic [255:0] exp,
                               input logic chk_it, input logic push);
        sb_t e;
        @(negedge clock);
        start     = 1'b1;
        init_hash = iv;
        if (push) begin
            e.chk = chk_it;
            e.exp = exp;
            sb_q.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (done) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
    endtask

    task automatic wait_read(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (w_read) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no w_read expected w_read within 30 cycles", name);
    endtask

    initial begin
        int first;
        int nreads;
        int addr_err;
        int done_at;
        int busy_at_done;

        total     = 0;
        bad       = 0;
        prev_done = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        init_hash = 256'h0;
        w_rdy     = 1'b1;
        for (int t = 0; t < 64; t++) wmem[t] = 32'h0;

        fork
            begin
                #2ms;
                $display("FAIL watchdog: got hang expected completion");
                $fatal(1, "watchdog");
            end
            forever begin
                sb_t e;
                @(negedge clock);
                if (done) begin
                    chk_int("done_one_cycle", int'(prev_done), 0);
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done expected no pending block");
                    end else begin
                        e = sb_q.pop_front();
                        if (e.chk) chk("digest", hash_out, e.exp);
                    end
                end
                prev_done = done;
            end
        join_none

        repeat (3) @(negedge clock);
        chk("reset_hash_out", hash_out, 256'h0);
        chk_int("reset_ctrl", int'({w_read, w_addr, busy, done}), 0);
        reset = 1'b0;

        // "abc", then a start held through DONE must be ignored
        load_msg(c_msg_abc);
        start_block(c_iv, c_exp_abc, 1'b1, 1'b1);
        wait_done("abc");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk_int("start_in_done_ignored", int'(busy), 0);

        // empty message, with a w_rdy drop mid-round
        load_msg(c_msg_empty);
        start_block(c_iv, c_exp_empty, 1'b1, 1'b1);
        repeat (10) @(negedge clock);
        w_rdy = 1'b0;
        repeat (5) @(negedge clock);
        w_rdy = 1'b1;
        wait_done("empty");

        // two-block message chained through hash_out
        load_msg(c_msg_b1);
        start_block(c_iv, 256'h0, 1'b0, 1'b1);
        wait_done("two_b1");
        mid_hash = hash_out;
        load_msg(c_msg_b2);
        start_block(mid_hash, c_exp_two, 1'b1, 1'b1);
        wait_done("two_b2");

        // handshake timing with w_rdy held low
        w_rdy = 1'b0;
        load_msg(c_msg_abc);
        start_block(c_iv, c_exp_abc, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk_int("no_read_while_waiting", int'(w_read), 0);
            @(negedge clock);
        end
        w_rdy = 1'b1;
        first = -1; nreads = 0; addr_err = 0; done_at = -1; busy_at_done = 0;
        for (int i = 0; i < 200 && done_at < 0; i++) begin
            @(negedge clock);
            if (w_read) begin
                if (first < 0) first = i;
                if (int'(w_addr) != nreads) addr_err++;
                nreads++;
            end else if (first >= 0 && nreads < 64) begin
                addr_err++;
            end
            if (done) begin
                done_at = i;
                busy_at_done = int'(busy);
            end
        end
        chk_int("read_count", nreads, 64);
        chk_int("addr_sequence_errors", addr_err, 0);
        chk_int("read_to_done_cycles", done_at - first, 67);
        chk_int("busy_at_done", busy_at_done, 1);
        @(negedge clock);
        chk_int("busy_after_done", int'(busy), 0);

        // start and init_hash change at round 20 are ignored
        start_block(c_iv, c_exp_abc, 1'b1, 1'b1);
        wait_read("ignored_start");
        repeat (22) @(negedge clock);
        start     = 1'b1;
        init_hash = ~c_iv;
        @(negedge clock);
        start = 1'b0;
        wait_done("ignored_start");

        // reset at round 30, then a fresh run
        start_block(c_iv, 256'h0, 1'b0, 1'b0);
        wait_read("mid_reset");
        repeat (32) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_reset_hash_out", hash_out, 256'h0);
        chk_int("mid_reset_ctrl", int'({w_read, w_addr, busy, done}), 0);
        start_block(c_iv, c_exp_abc, 1'b1, 1'b1);
        wait_done("after_reset");

        repeat (5) @(negedge clock);
        chk_int("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
